ysyx_23060236_axi_sram: RTL and testbench

AXI4 slave memory placed directly downstream of the core's io_master port. Lets the CPU run standalone without the SoC, serving IFU instruction bursts and LSU loads/stores.
Single outstanding transaction, 32-bit data, INCR/FIXED bursts, byte strobes, programmable read latency, address decode with error response.

---
 rtl/ysyx_23060236_axi_sram.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_23060236_axi_sram.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_axi_sram.sv
// rtl/ysyx_23060236_axi_sram.sv - AXI4 slave SRAM model for standalone core runs
//
// Single-outstanding AXI4 slave backed by a DEPTH x 32-bit word array.
// Handles INCR/FIXED bursts, byte strobes, a programmable read latency and
// per-beat address decode with DECERR/SLVERR responses.
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   aw*  (awready out)                write address channel
//   w*   (wready out)                 write data channel
//   b*   (bvalid/bresp/bid out)       write response channel
//   ar*  (arready out)                read address channel
//   r*   (rvalid/rresp/rdata/rlast/rid out) read data channel
module ysyx_23060236_axi_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          READ_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT  = 4'(READ_LAT);

    logic [31:0] mem [DEPTH];

    logic [2:0]  state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic        slv_q, slv_d;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          legal;
    logic          last_beat;
    logic [31:0]   next_addr;
    logic          ar_hs, aw_hs, r_hs, w_hs, b_hs;

    // Transfer size is irrelevant: reads return the whole word, writes obey wstrb.
    logic unused_size;
    assign unused_size = ^{arsize, awsize};

    // Offset arithmetic is modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = off < SPAN;
    assign idx       = off[AW+1:2];
    assign legal     = !burst_q[1];
    assign last_beat = beat_q == len_q;
    assign next_addr = (burst_q == 2'b01) ? addr_q + 32'd4 : addr_q;

    // Handshake outputs are forced low while reset is held.
    assign arready = !reset && state_q == S_IDLE;
    assign awready = arready && !arvalid;
    assign rvalid  = !reset && state_q == S_RD_DATA;
    assign wready  = !reset && state_q == S_WR_DATA;
    assign bvalid  = !reset && state_q == S_WR_RESP;

    assign ar_hs = arready && arvalid;
    assign aw_hs = awready && awvalid;
    assign r_hs  = rvalid && rready;
    assign w_hs  = wready && wvalid;
    assign b_hs  = bvalid && bready;

    // Read beat is derived from registered burst state, so it stays put while stalled.
    assign rdata = (rvalid && legal && in_range) ? mem[idx] : 32'h0;
    assign rresp = !rvalid  ? 2'b00 :
                   !legal   ? 2'b10 :
                   !in_range ? 2'b11 : 2'b00;
    assign rlast = rvalid && last_beat;
    assign rid   = id_q;
    assign bid   = id_q;
    assign bresp = !bvalid ? 2'b00 :
                   dec_q   ? 2'b11 :
                   slv_q   ? 2'b10 : 2'b00;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        slv_d   = slv_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    burst_d = arburst;
                    beat_d  = 8'd0;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? S_RD_DATA : S_RD_WAIT;
                end else if (aw_hs) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    burst_d = awburst;
                    beat_d  = 8'd0;
                    dec_d   = 1'b0;
                    slv_d   = 1'b0;
                    state_d = S_WR_DATA;
                end
            end
            S_RD_WAIT: begin
                // The cycle holding count 1 is the last wait cycle, giving READ_LAT wait cycles.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (r_hs) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            S_WR_DATA: begin
                if (w_hs) begin
                    if (!in_range) begin
                        dec_d = 1'b1;
                    end
                    if (!legal || (wlast != last_beat)) begin
                        slv_d = 1'b1;
                    end
                    addr_d = next_addr;
                    if (last_beat) begin
                        state_d = S_WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            id_q    <= 4'd0;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            burst_q <= 2'd0;
            beat_q  <= 8'd0;
            cnt_q   <= 4'd0;
            dec_q   <= 1'b0;
            slv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            slv_q   <= slv_d;
        end
    end

    // Memory contents survive reset; illegal-burst and out-of-range beats are dropped.
    always_ff @(posedge clock) begin
        if (w_hs && in_range && legal) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_axi_sram.sv
// tb/tb_ysyx_23060236_axi_sram.sv - scoreboard testbench for ysyx_23060236_axi_sram
module tb_ysyx_23060236_axi_sram;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    ysyx_23060236_axi_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .READ_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;
    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t exp_r[$];
    bexp_t exp_b[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every R/B handshake and checks stall stability.
    logic        hold_v = 1'b0;
    logic [38:0] hold_val;
    always @(negedge clock) begin
        rexp_t er;
        bexp_t eb;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (rvalid) begin
                if (hold_v) check("r_hold", {rdata, rresp, rlast, rid}, hold_val);
                if (rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", {rdata, rresp, rlast, rid}, 64'hX);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_beat", {rdata, rresp, rlast, rid}, er);
                    end
                end
            end
            hold_v   = rvalid && !rready;
            hold_val = {rdata, rresp, rlast, rid};
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", {bresp, bid}, 64'hX);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_resp", {bresp, bid}, eb);
                end
            end
        end
    end

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        exp_r.push_back({d, resp, last, id});
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst);
        bit ok = 0;
        @(posedge clock); #1;
        awvalid = 1; awaddr = addr; awid = id; awlen = 8'd0; awburst = burst;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) check("aw_timeout", 0, 1);
        @(posedge clock); #1;
        awvalid = 0;
    endtask

    task automatic w_phase(input logic [31:0] d, input logic [3:0] strb, input logic last);
        bit ok = 0;
        @(posedge clock); #1;
        wvalid = 1; wdata = d; wstrb = strb; wlast = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (wready) begin ok = 1; break; end
        end
        if (!ok) check("w_timeout", 0, 1);
        @(posedge clock); #1;
        wvalid = 0;
    endtask

    task automatic wait_b();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            if (exp_b.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("b_timeout", 0, 1);
    endtask

    task automatic write1(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                          input logic [3:0] id, input logic last, input logic [1:0] burst,
                          input logic [1:0] exp_resp);
        exp_b.push_back({exp_resp, id});
        aw_phase(addr, id, burst);
        w_phase(d, strb, last);
        wait_b();
    endtask

    // pat bit k = rready in the k-th cycle counted from the expected first rvalid.
    // abort_after != 0 returns at the negedge preceding that many handshakes.
    task automatic read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input logic [15:0] pat, input int abort_after);
        bit ok = 0;
        int beats = 0;
        @(posedge clock); #1;
        arvalid = 1; araddr = addr; arid = id; arlen = len; arburst = burst; rready = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) check("ar_timeout", 0, 1);
        @(posedge clock); #1;
        arvalid = 0;
        ok = 0;
        for (int k = 1; k < 400; k++) begin
            rready = (k <= LAT) ? 1'b0 : ((k - LAT - 1) < 16) ? pat[k - LAT - 1] : 1'b1;
            @(negedge clock);
            if (k <= LAT + 1) check("r_latency", rvalid, (k == LAT + 1));
            if (rvalid && rready) beats++;
            if (beats == int'(len) + 1 || (abort_after != 0 && beats == abort_after)) begin
                ok = 1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!ok) check("r_timeout", beats, int'(len) + 1);
        if (abort_after == 0) begin
            @(posedge clock); #1;
            rready = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        bit done;
        reset = 1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; rready = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ready", {awready, wready, arready}, 3'b000);
        check("reset_valid", {bvalid, rvalid, rlast}, 3'b000);
        check("reset_data", {bresp, rresp, rdata, bid, rid}, 44'h0);
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check("idle_ready", {arready, awready}, 2'b11);

        // 1: basic word write then read back
        write1(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 4'd3, 1'b1, 2'b01, 2'b00);
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd5);
        read(32'h8000_0000, 4'd5, 8'd0, 2'b01, 16'hFFFF, 0);

        // 2: byte-strobed merge
        write1(32'h8000_0004, 32'h1122_3344, 4'hF, 4'd1, 1'b1, 2'b01, 2'b00);
        write1(32'h8000_0004, 32'h0000_00AA, 4'b0001, 4'd1, 1'b1, 2'b01, 2'b00);
        push_r(32'h1122_33AA, 2'b00, 1'b1, 4'd2);
        read(32'h8000_0004, 4'd2, 8'd0, 2'b01, 16'hFFFF, 0);

        // 3: INCR burst with rready back-pressure 1,0,1,1,0,1
        for (int i = 0; i < 4; i++)
            write1(32'h8000_0010 + 32'(4 * i), 32'(i + 1), 4'hF, 4'd0, 1'b1, 2'b01, 2'b00);
        for (int i = 0; i < 4; i++)
            push_r(32'(i + 1), 2'b00, (i == 3), 4'd6);
        read(32'h8000_0010, 4'd6, 8'd3, 2'b01, 16'h002D, 0);

        // FIXED burst keeps the address
        push_r(32'd1, 2'b00, 1'b0, 4'd8);
        push_r(32'd1, 2'b00, 1'b1, 4'd8);
        read(32'h8000_0010, 4'd8, 8'd1, 2'b00, 16'hFFFF, 0);

        // 4: simultaneous AR and AW, read wins
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd7);
        exp_b.push_back({2'b00, 4'd9});
        @(posedge clock); #1;
        arvalid = 1; araddr = 32'h8000_0000; arid = 4'd7; arlen = 0; arburst = 2'b01;
        awvalid = 1; awaddr = 32'h8000_0008; awid = 4'd9; awlen = 0; awburst = 2'b01;
        rready = 1;
        @(negedge clock);
        check("arb_arready", arready, 1'b1);
        check("arb_awready", awready, 1'b0);
        @(posedge clock); #1;
        arvalid = 0;
        bad = 0; done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (awready) bad = 1;
            if (rvalid && rready) begin done = 1; break; end
        end
        check("arb_aw_held", bad, 1'b0);
        check("arb_r_done", done, 1'b1);
        @(negedge clock);
        check("arb_aw_after", awready, 1'b1);
        @(posedge clock); #1;
        awvalid = 0; rready = 0;
        w_phase(32'h0000_0055, 4'hF, 1'b1);
        wait_b();
        push_r(32'h0000_0055, 2'b00, 1'b1, 4'd7);
        read(32'h8000_0008, 4'd7, 8'd0, 2'b01, 16'hFFFF, 0);

        // 5: decode errors and illegal bursts
        push_r(32'h0, 2'b11, 1'b1, 4'd4);
        read(32'h7FFF_FFFC, 4'd4, 8'd0, 2'b01, 16'hFFFF, 0);
        write1(32'h9000_0000, 32'h1234_5678, 4'hF, 4'd1, 1'b1, 2'b01, 2'b11);
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd4);
        read(32'h8000_0000, 4'd4, 8'd0, 2'b01, 16'hFFFF, 0);
        push_r(32'h0, 2'b10, 1'b1, 4'd4);
        read(32'h8000_0000, 4'd4, 8'd0, 2'b10, 16'hFFFF, 0);

        // top word in range, one past it out of range
        write1(32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 4'd2, 1'b1, 2'b01, 2'b00);
        push_r(32'hA5A5_5A5A, 2'b00, 1'b1, 4'd3);
        read(32'h8000_3FFC, 4'd3, 8'd0, 2'b01, 16'hFFFF, 0);
        push_r(32'h0, 2'b11, 1'b1, 4'd3);
        read(32'h8000_4000, 4'd3, 8'd0, 2'b01, 16'hFFFF, 0);

        // wlast mismatch: SLVERR but data still written
        write1(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 4'd4, 1'b0, 2'b01, 2'b10);
        push_r(32'hCAFE_F00D, 2'b00, 1'b1, 4'd1);
        read(32'h8000_0020, 4'd1, 8'd0, 2'b01, 16'hFFFF, 0);

        // illegal-burst write is dropped
        write1(32'h8000_0024, 32'h0000_600D, 4'hF, 4'd5, 1'b1, 2'b01, 2'b00);
        write1(32'h8000_0024, 32'h0000_0BAD, 4'hF, 4'd6, 1'b1, 2'b11, 2'b10);
        push_r(32'h0000_600D, 2'b00, 1'b1, 4'd1);
        read(32'h8000_0024, 4'd1, 8'd0, 2'b01, 16'hFFFF, 0);

        // 6: reset during beat 2 of a 4-beat read
        for (int i = 0; i < 4; i++)
            push_r(32'(i + 1), 2'b00, (i == 3), 4'd2);
        read(32'h8000_0010, 4'd2, 8'd3, 2'b01, 16'hFFFF, 2);
        @(posedge clock); #1;
        reset = 1;
        @(negedge clock);
        check("rst_mid_arready", arready, 1'b0);
        @(posedge clock); #1;
        reset = 0;
        exp_r.delete();
        @(negedge clock);
        check("rst_mid_rvalid", rvalid, 1'b0);
        check("rst_mid_arready_after", arready, 1'b1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rvalid) bad = 1;
        end
        check("rst_no_more_beats", bad, 1'b0);
        rready = 0;

        repeat (2) @(posedge clock);
        check("r_queue_empty", exp_r.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
